// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_scan_ctrl: binary->BCD (double-dabble) plus 3-digit multiplexed scan. |
// | Optional macro DISP_SCAN_BLANK_EN: leading-zero blanking. Rev 1.0          |
// +--------------------------------------------------------------------------+
module disp_scan_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] val,
  input  logic       load,
  output logic       busy,
  output logic       bcd_valid,
  output logic [3:0] digit,
  output logic [2:0] dig_en
);

  localparam int            PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] c_presc_max = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [8:0]     bin_q, bin_d;
  logic [11:0]    bcd_q, bcd_d;
  logic [10:0]    bcd_adj;
  logic [3:0]     step_q, step_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic [11:0]    disp_q, disp_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [1:0]     idx_q, idx_d;
  logic [3:0]     digit_q, digit_d;
  logic [2:0]     dig_en_q, dig_en_d;

  // Conversion FSM
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    disp_d  = disp_q;

    // Hundreds never reaches 5 before the last shift of a 9-bit input.
    bcd_adj = bcd_q[10:0];
    for (int i = 0; i < 2; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = val;
          bcd_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
        step_d         = step_q + 4'd1;
        if (step_q == 4'd8) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d  = bcd_q;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scanner: outputs pair the next index with the current (pre-commit) display
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == c_presc_max) begin
      presc_d = '0;
      idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end

    case (idx_d)
      2'd0:    digit_d = disp_q[3:0];
      2'd1:    digit_d = disp_q[7:4];
      default: digit_d = disp_q[11:8];
    endcase

    dig_en_d = 3'b001 << idx_d;
`ifdef DISP_SCAN_BLANK_EN
    if ((idx_d == 2'd2) && (disp_q[11:8] == 4'd0)) begin
      dig_en_d = 3'b000;
    end
    if ((idx_d == 2'd1) && (disp_q[11:4] == 8'd0)) begin
      dig_en_d = 3'b000;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      disp_q   <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      digit_q  <= 4'd0;
      dig_en_q <= 3'b001;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      disp_q   <= disp_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      digit_q  <= digit_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_valid = valid_q;
  assign digit     = digit_q;
  assign dig_en    = dig_en_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_disp_scan_ctrl: self-checking bench with a cycle-level reference model. |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_disp_scan_ctrl;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic [8:0] val;
  logic       load;
  logic       busy;
  logic       bcd_valid;
  logic [3:0] digit;
  logic [2:0] dig_en;

  int n_checks;
  int n_errors;

  // Reference model state
  int m_disp;
  int m_out_val;
  int m_out_idx;
  int m_left;
  int m_pend;
  int m_valid;
  int m_cyc;
  int busy_cycles;

  disp_scan_ctrl #(.SCAN_DIV(SCAN_DIV)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .val       (val),
    .load      (load),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .digit     (digit),
    .dig_en    (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int pow10(input int i);
    return (i == 0) ? 1 : (i == 1) ? 10 : 100;
  endfunction

  function automatic int exp_en(input int v, input int idx);
    int en;
    en = 1 << idx;
`ifdef DISP_SCAN_BLANK_EN
    if (idx == 2 && v < 100) en = 0;
    if (idx == 1 && v < 10)  en = 0;
`endif
    return en;
  endfunction

  // Predict the effect of one clock edge given the inputs presented to it.
  task automatic model_edge(input logic r, input logic ld, input int v);
    if (r) begin
      m_disp = 0; m_left = 0; m_valid = 0; m_cyc = 0;
      m_out_val = 0; m_out_idx = 0;
    end else begin
      m_out_val = m_disp;
      m_cyc++;
      m_out_idx = (m_cyc / SCAN_DIV) % 3;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_disp  = m_pend;
          m_valid = 1;
        end
      end else if (ld) begin
        m_pend = v;
        m_left = 10;
      end
    end
  endtask

  task automatic step(input logic r, input logic ld, input int v);
    rst  = r;
    load = ld;
    val  = 9'(v);
    @(posedge clk);
    model_edge(r, ld, v);
    @(negedge clk);
    if (busy) busy_cycles++;
    check("busy", int'(busy), (m_left > 0) ? 1 : 0);
    check("bcd_valid", int'(bcd_valid), m_valid);
    check("digit", int'(digit), (m_out_val / pow10(m_out_idx)) % 10);
    check("dig_en", int'(dig_en), exp_en(m_out_val, m_out_idx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic do_load(input int v);
    step(1'b0, 1'b1, v);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; busy_cycles = 0;
    m_disp = 0; m_out_val = 0; m_out_idx = 0; m_left = 0;
    m_pend = 0; m_valid = 0; m_cyc = 0;
    rst = 1'b1; load = 1'b0; val = '0;

    // Reset, then free-running scan
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(6);

    // 120: busy length, then full scan
    busy_cycles = 0;
    do_load(120);
    idle(24);
    check("busy_len_120", busy_cycles, 10);

    // Extremes
    do_load(511); idle(16);
    do_load(0);   idle(16);

    // Load while busy is dropped
    do_load(120); idle(2);
    do_load(77);  idle(20);

    // Load on the commit cycle is dropped too
    do_load(250); idle(9);
    do_load(33);  idle(16);

    // Reset in mid-conversion
    do_load(300); idle(5);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(3);
    do_load(45);  idle(16);

    // Single-digit value exercises blanking
    do_load(7);   idle(16);

    // Randomized loads, gaps and occasional reset
    for (int k = 0; k < 60; k++) begin
      int gap;
      gap = $urandom_range(0, 14);
      do_load($urandom_range(0, 511));
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 99) == 0) step(1'b1, 1'b0, 0);
        else step(1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, $urandom_range(0, 511));
      end
    end
    idle(16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
